// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - FIFO drain controller feeding a 2-entry skid buffer
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-low reset
//   enable_i     drain enable (1 = issue pops, 0 = stop issuing new pops)
//   count_i      FIFO occupancy, $clog2(depth)+1 bits
//   fifo_data_i  FIFO read data, valid the cycle after pop_o = 1
//   pop_o        FIFO pop request, combinational, one word per cycle
//   out_valid_o  downstream word valid
//   out_data_o   downstream word (oldest buffered word)
//   out_ready_i  downstream ready
//   busy_o       read in flight or skid buffer non-empty
module fifo_drain_ctrl #(
   parameter int depth = 16,
   parameter int width = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic [$clog2(depth):0] count_i,
   input  logic [width-1:0]       fifo_data_i,
   output logic                   pop_o,
   output logic                   out_valid_o,
   output logic [width-1:0]       out_data_o,
   input  logic                   out_ready_i,
   output logic                   busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             rd_q;
   logic [1:0]       occ_q;
   logic             head_q;
   logic [width-1:0] buf_q [0:1];

   logic             push;
   logic             pull;
   logic             tail;
   logic             pop_state_ok;
   logic [2:0]       resv;
   logic [2:0]       resv_after_pull;

   assign push        = rd_q;
   assign out_valid_o = (occ_q != 2'd0);
   assign pull        = out_valid_o & out_ready_i;
   assign busy_o      = rd_q | (occ_q != 2'd0);
   assign out_data_o  = buf_q[head_q];

   // With one word buffered the tail is the slot after the head; when the
   // buffer is empty the head slot itself is written.
   assign tail = head_q ^ (occ_q == 2'd1);

   // Slots already claimed: buffered words plus the word in flight.
   assign resv = {1'b0, occ_q} + {2'b0, rd_q};

   // A word handed downstream this cycle frees its slot at the same edge,
   // which is what lets the drain sustain one word per cycle; the claimed
   // count after this edge still never exceeds two.
   assign resv_after_pull = resv - {2'b0, pull};

   always_comb begin
      state_d      = state_q;
      pop_state_ok = 1'b0;
      case (state_q)
         IDLE: begin
            pop_state_ok = enable_i;
            if (enable_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            pop_state_ok = 1'b1;
            if (!enable_i) begin
               state_d = busy_o ? FLUSH : IDLE;
            end
         end
         FLUSH: begin
            if (enable_i) begin
               state_d = RUN;
            end else if (!busy_o) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Gated by rst_i so no pop can escape while reset is held, without
   // waiting for a clock edge.
   assign pop_o = rst_i & enable_i & (count_i != '0) & pop_state_ok &
                  (resv_after_pull < 3'd2);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         rd_q     <= 1'b0;
         occ_q    <= 2'd0;
         head_q   <= 1'b0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= pop_o;
         if (push) begin
            buf_q[tail] <= fifo_data_i;
         end
         if (pull) begin
            head_q <= ~head_q;
         end
         case ({push, pull})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      resv <= 3'd2);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - self-checking bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;

   localparam int depth = 16;
   localparam int width = 32;
   localparam int cw    = $clog2(depth) + 1;

   logic             clk_i       = 1'b0;
   logic             rst_i       = 1'b1;
   logic             enable_i    = 1'b0;
   logic             out_ready_i = 1'b0;
   logic [cw-1:0]    count_i     = '0;
   logic [width-1:0] fifo_data_i = '0;
   logic             pop_o;
   logic             out_valid_o;
   logic [width-1:0] out_data_o;
   logic             busy_o;

   fifo_drain_ctrl #(.depth(depth), .width(width)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .count_i     (count_i),
      .fifo_data_i (fifo_data_i),
      .pop_o       (pop_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // FIFO contents behind the DUT, and the reference model:
   // mq = words held downstream of the FIFO (oldest first), m_fl = a word in flight.
   logic [width-1:0] fifo_q [$];
   logic [width-1:0] mq [$];
   logic             m_fl = 1'b0;
   logic [width-1:0] m_fl_word = '0;
   int               m_st = 0;   // 0 idle, 1 run, 2 flush
   int               cyc = 0;
   int               pop_cyc [$];
   int               hs_cyc [$];
   logic [width-1:0] hs_data [$];

   function automatic logic m_busy();
      return m_fl || (mq.size() != 0);
   endfunction

   function automatic logic m_pop();
      int leaving;
      leaving = ((mq.size() != 0) && out_ready_i) ? 1 : 0;
      return rst_i && enable_i && (count_i != 0) && (m_st != 2) &&
             ((mq.size() + int'(m_fl) - leaving) < 2);
   endfunction

   always @(posedge clk_i) begin
      logic b, p, hs;
      cyc = cyc + 1;
      if (!rst_i) begin
         mq.delete();
         m_fl = 1'b0;
         m_st = 0;
      end else begin
         b  = m_busy();
         p  = m_pop();
         hs = (mq.size() != 0) && out_ready_i;
         case (m_st)
            0:       if (enable_i) m_st = 1;
            1:       if (!enable_i) m_st = b ? 2 : 0;
            default: if (enable_i) m_st = 1; else if (!b) m_st = 0;
         endcase
         if (hs) void'(mq.pop_front());
         if (m_fl) mq.push_back(m_fl_word);
         m_fl = p;
         if (p && fifo_q.size() != 0) m_fl_word = fifo_q[0];
      end
      if (pop_o) begin
         pop_cyc.push_back(cyc);
         if (fifo_q.size() != 0) begin
            fifo_data_i <= fifo_q.pop_front();
            count_i     <= cw'(fifo_q.size());
         end
      end else begin
         fifo_data_i <= 32'hDEAD_BEEF;
      end
      if (rst_i && out_valid_o && out_ready_i) begin
         hs_cyc.push_back(cyc);
         hs_data.push_back(out_data_o);
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i) begin
         check("rst_pop",   pop_o,       1'b0);
         check("rst_valid", out_valid_o, 1'b0);
         check("rst_data",  out_data_o,  '0);
         check("rst_busy",  busy_o,      1'b0);
      end else begin
         check("pop",   pop_o,       m_pop());
         check("valid", out_valid_o, mq.size() != 0);
         if (mq.size() != 0) check("data", out_data_o, mq[0]);
         check("busy",  busy_o,      m_busy());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic load(input logic [width-1:0] base, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + width'(i));
      count_i = cw'(fifo_q.size());
   endtask

   task automatic clear_logs();
      pop_cyc.delete();
      hs_cyc.delete();
      hs_data.delete();
   endtask

   task automatic check_seq(input string tag, input logic [width-1:0] base, input int n);
      check({tag, "_count"}, hs_data.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_word%0d", tag, i),
               (i < hs_data.size()) ? hs_data[i] : 'x, base + width'(i));
   endtask

   initial begin
      int k;
      // Reset held with work pending
      #1 rst_i = 1'b0;
      load(32'h100, 5);
      enable_i    = 1'b1;
      out_ready_i = 1'b1;
      tick(3);
      check("s1_rst_pop",   pop_o,       1'b0);
      check("s1_rst_valid", out_valid_o, 1'b0);
      clear_logs();
      rst_i = 1'b1;
      #1;
      check("s1_first_pop", pop_o, 1'b1);
      tick(10);
      check_seq("s1", 32'h100, 5);

      // Three words, ready held high: back-to-back pops and deliveries
      clear_logs();
      k = cyc;
      load(32'hA, 3);
      tick(8);
      check("s2_pops", pop_cyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("s2_pop_cyc%0d", i), (i < pop_cyc.size()) ? pop_cyc[i] : -1, k + 1 + i);
         check($sformatf("s2_hs_cyc%0d", i),  (i < hs_cyc.size())  ? hs_cyc[i]  : -1, k + 3 + i);
      end
      check_seq("s2", 32'hA, 3);
      check("s2_pop_empty", pop_o, 1'b0);

      // Downstream stalled: only two pops, head held
      clear_logs();
      out_ready_i = 1'b0;
      load(32'h300, 8);
      tick(6);
      check("s3_pops",  pop_cyc.size(), 2);
      check("s3_valid", out_valid_o,    1'b1);
      check("s3_head",  out_data_o,     32'h300);
      check("s3_pop",   pop_o,          1'b0);
      check("s3_count", count_i,        6);
      tick(2);
      check("s3_head_hold", out_data_o, 32'h300);
      out_ready_i = 1'b1;
      tick(14);
      check_seq("s3", 32'h300, 8);

      // Ready toggling every cycle over a full FIFO
      clear_logs();
      load(32'h400, 16);
      for (int i = 0; i < 44; i++) begin
         out_ready_i = ~out_ready_i;
         tick(1);
      end
      out_ready_i = 1'b1;
      tick(6);
      check_seq("s4", 32'h400, 16);

      // Enable dropped the cycle after a pop
      clear_logs();
      k = cyc;
      load(32'h500, 4);
      tick(1);
      enable_i = 1'b0;
      #1;
      check("s5_pop_off",   pop_o,  1'b0);
      check("s5_busy_fly",  busy_o, 1'b1);
      tick(1);
      check("s5_valid",     out_valid_o, 1'b1);
      check("s5_data",      out_data_o,  32'h500);
      check("s5_busy_buf",  busy_o,      1'b1);
      tick(1);
      check("s5_busy_fall", busy_o, 1'b0);
      tick(3);
      check("s5_pops",   pop_cyc.size(), 1);
      check("s5_hs_cyc", (hs_cyc.size() != 0) ? hs_cyc[0] : -1, k + 3);
      check("s5_count",  count_i, 3);
      enable_i = 1'b1;
      #1;
      check("s5_resume", pop_o, 1'b1);
      tick(8);
      check_seq("s5", 32'h500, 4);

      // Reset with the buffer reservation full
      clear_logs();
      out_ready_i = 1'b0;
      load(32'h600, 4);
      tick(2);
      check("s6_busy_pre",  busy_o,      1'b1);
      check("s6_valid_pre", out_valid_o, 1'b1);
      check("s6_pop_pre",   pop_o,       1'b0);
      rst_i = 1'b0;
      #1;
      check("s6_rst_pop",   pop_o,       1'b0);
      check("s6_rst_valid", out_valid_o, 1'b0);
      check("s6_rst_data",  out_data_o,  '0);
      check("s6_rst_busy",  busy_o,      1'b0);
      fifo_q.delete();
      count_i = '0;
      tick(2);
      rst_i = 1'b1;
      out_ready_i = 1'b1;
      tick(5);
      check("s6_valid_post", out_valid_o,    1'b0);
      check("s6_busy_post",  busy_o,         1'b0);
      check("s6_pops",       pop_cyc.size(), 2);
      check("s6_hs",         hs_cyc.size(),  0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
